// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared MDU operation codes and FSM state encoding
package muldiv_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between decoder/pipeline and the MDU
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, flush, input hi, lo, busy, done);
  modport slave  (input start, op, a, b, flush, output hi, lo, busy, done);
endinterface

// File: rtl/muldiv_div_iter.sv
// rtl/muldiv_div_iter.sv - restoring radix-2 divider datapath, one quotient bit per step
module muldiv_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_last,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_dvsr;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Dividend bits shift out of r_quot into the partial remainder while quotient bits shift in.
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvsr});
  assign w_diff  = w_shift[WIDTH-1:0] - r_dvsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_dvsr <= '0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_dvsr <= i_divisor;
    end else if (i_step) begin
      r_cnt  <= r_cnt + 1'b1;
      r_rem  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
      r_quot <= {r_quot[WIDTH-2:0], w_ge};
    end
  end

  assign o_last = (r_cnt == CW'(WIDTH - 1));
  assign o_quot = r_quot;
  assign o_rem  = r_rem;
endmodule

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  mdu_state_t r_state;
  mdu_state_t w_next;

  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic w_busy, w_accept, w_load, w_step, w_write, w_last;

  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;
  logic               w_signed, w_neg_q, w_neg_r;
  logic [WIDTH-1:0]   w_hi_nx, w_lo_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) w_next = bus.op[1] ? ST_DIV : ST_MUL;
        ST_MUL:  w_next = ST_FIX;
        ST_DIV:  if (w_last) w_next = ST_FIX;
        ST_FIX:  w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy   = (r_state != ST_IDLE);
    w_accept = (r_state == ST_IDLE) && bus.start && !bus.flush;
    w_load   = w_accept && bus.op[1];
    w_step   = (r_state == ST_DIV) && !bus.flush;
    w_write  = (r_state == ST_FIX) && !bus.flush;
  end

  // Magnitudes go straight from the request into the divider so iteration starts next cycle.
  assign w_mag_a = ((bus.op == MDU_DIV) && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_mag_b = ((bus.op == MDU_DIV) && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  muldiv_div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_last     (w_last),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_ext_a = r_op[0] ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_ext_b = r_op[0] ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  assign w_signed = (r_op == MDU_DIV);
  assign w_neg_q  = w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
  assign w_neg_r  = w_signed && r_a[WIDTH-1];

  // Divide by zero bypasses the sign fix-up and reports the raw dividend in HI.
  always_comb begin
    w_hi_nx = r_prod[2*WIDTH-1:WIDTH];
    w_lo_nx = r_prod[WIDTH-1:0];
    if (r_op[1]) begin
      if (r_b == '0) begin
        w_hi_nx = r_a;
        w_lo_nx = '1;
      end else begin
        w_hi_nx = w_neg_r ? -w_rem  : w_rem;
        w_lo_nx = w_neg_q ? -w_quot : w_quot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= bus.op;
        r_a  <= bus.a;
        r_b  <= bus.b;
      end
      if (r_state == ST_MUL) r_prod <= w_prod;
      if (w_write) begin
        r_hi <= w_hi_nx;
        r_lo <= w_lo_nx;
      end
      r_done <= w_write;
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = w_busy;
  assign bus.done = r_done;
endmodule
